// File: rtl/mux4_if.sv
// -----------------------------------------------------------------------------
// mux4_if -- bus bundle for the registered 4:1 multiplexer.
//
// Handshake: there is no back-pressure. The driver presents din1..din4,
// select and en. Each rising clk edge with en=1 is one capture. The mux
// answers one cycle later with dout/sel_out and dout_valid=1. dout_valid is
// high for exactly the cycle after each capture. There is no ready signal,
// because the mux accepts a capture on every cycle.
//
// Signals (WIDTH = data width, 1..64):
//   din1..din4  WIDTH  data channels 0..3               (master -> slave)
//   select      2      channel index                    (master -> slave)
//   en          1      capture enable                   (master -> slave)
//   dout        WIDTH  registered selected data         (slave -> master)
//   dout_valid  1      high the cycle after a capture   (slave -> master)
//   sel_out     2      select value behind dout         (slave -> master)
//   dout_par    1      XOR of dout bits, present only when MUX4_PARITY_EN
//                      is defined                       (slave -> master)
// -----------------------------------------------------------------------------
interface mux4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [WIDTH-1:0] din4;
  logic [1:0]       select;
  logic             en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [1:0]       sel_out;
`ifdef MUX4_PARITY_EN
  logic             dout_par;
`endif

  modport master (
    output din1, din2, din3, din4, select, en,
`ifdef MUX4_PARITY_EN
    input  dout_par,
`endif
    input  dout, dout_valid, sel_out
  );

  modport slave (
    input  din1, din2, din3, din4, select, en,
`ifdef MUX4_PARITY_EN
    output dout_par,
`endif
    output dout, dout_valid, sel_out
  );
endinterface

// File: rtl/mux4.sv
// -----------------------------------------------------------------------------
// mux4 -- registered 4:1 multiplexer with one-cycle latency.
//
// Ports:
//   clk  input   sole clock; all state updates happen on its rising edge
//   rst  input   asynchronous active-high reset; clears every output at once
//   bus  mux4_if.slave
//        din1..din4 select en      inputs
//        dout dout_valid sel_out   outputs (dout_par is also an output when
//                                  MUX4_PARITY_EN is defined)
//
// Optional feature: define MUX4_PARITY_EN to add the dout_par output. This
// output is registered together with dout and holds the XOR of all dout bits.
// Without the macro, the port and its register do not exist.
// -----------------------------------------------------------------------------
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  mux4_if.slave    bus
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;

  // Full decode with no priority. A select value that matches no legal
  // index (X/Z in simulation) falls to the default and loads zeros.
  always_comb begin
    mux_d = '0;
    case (bus.select)
      2'd0:    mux_d = bus.din1;
      2'd1:    mux_d = bus.din2;
      2'd2:    mux_d = bus.din3;
      2'd3:    mux_d = bus.din4;
      default: mux_d = '0;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (bus.en) begin
      dout_d  = mux_d;
      sel_d   = bus.select;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel_out    = sel_q;
  assign bus.dout_valid = valid_q;

`ifdef MUX4_PARITY_EN
  logic par_q, par_d;

  // Parity is taken from the value being loaded, so it stays aligned
  // with dout. When en=0 the register holds its value along with dout.
  always_comb begin
    par_d = par_q;
    if (bus.en) par_d = ^mux_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign bus.dout_par = par_q;
`endif

endmodule

// File: tb/tb_mux4.sv
module tb_mux4;
  localparam int W = 8;
`ifdef MUX4_PARITY_EN
  localparam int EW = W + 4;
`else
  localparam int EW = W + 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux4_if #(.WIDTH(W)) bus ();
  mux4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- scoreboard ----------------
  // entry = {[par,] valid, sel, dout}
  logic [EW-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] m_dout;
  logic [1:0]   m_sel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [EW-1:0] e);
    check({tag, ".dout"},  64'(bus.dout),       64'(e[W-1:0]));
    check({tag, ".sel"},   64'(bus.sel_out),    64'(e[W+1:W]));
    check({tag, ".valid"}, 64'(bus.dout_valid), 64'(e[W+2]));
`ifdef MUX4_PARITY_EN
    check({tag, ".par"},   64'(bus.dout_par),   64'(e[W+3]));
`endif
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus after the falling edge, predicts the result,
  // and compares it 1 ns after the next rising edge. With glitch=1, select
  // moves through other values before it settles.
  task automatic step(input string tag, input logic [W-1:0] a, b, c, d,
                      input logic [1:0] s, input logic e, input bit glitch);
    logic [EW-1:0] pk;
    logic [EW-1:0] got;
    @(negedge clk);
    bus.din1 = a; bus.din2 = b; bus.din3 = c; bus.din4 = d;
    bus.en = e;
    if (glitch) begin
      bus.select = s + 2'd1; #1;
      bus.select = s + 2'd2; #1;
      bus.select = s + 2'd3; #1;
    end
    bus.select = s;
    if (e) begin
      m_sel = s;
      case (s)
        2'd0: m_dout = a;
        2'd1: m_dout = b;
        2'd2: m_dout = c;
        default: m_dout = d;
      endcase
    end
`ifdef MUX4_PARITY_EN
    pk = {^m_dout, e, m_sel, m_dout};
`else
    pk = {e, m_sel, m_dout};
`endif
    exp_q.push_back(pk);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    check_outputs(tag, got);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".dout"},  64'(bus.dout),       64'd0);
    check({tag, ".sel"},   64'(bus.sel_out),    64'd0);
    check({tag, ".valid"}, 64'(bus.dout_valid), 64'd0);
`ifdef MUX4_PARITY_EN
    check({tag, ".par"},   64'(bus.dout_par),   64'd0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    bus.din1 = '0; bus.din2 = '0; bus.din3 = '0; bus.din4 = '0;
    bus.select = 2'd0; bus.en = 1'b0;
    m_dout = '0; m_sel = 2'd0;
    #2;
    check_reset_vals("reset_init");
    @(negedge clk); rst = 1'b0;

    step("post_reset_idle", 8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b0, 1'b0);

    // select sweep, back to back
    step("sweep0", 8'h12, 8'h34, 8'h56, 8'h78, 2'd0, 1'b1, 1'b0);
    step("sweep1", 8'h12, 8'h34, 8'h56, 8'h78, 2'd1, 1'b1, 1'b0);
    step("sweep2", 8'h12, 8'h34, 8'h56, 8'h78, 2'd2, 1'b1, 1'b0);
    step("sweep3", 8'h12, 8'h34, 8'h56, 8'h78, 2'd3, 1'b1, 1'b0);

    // hold
    step("hold_cap", 8'h12, 8'h34, 8'h56, 8'h78, 2'd2, 1'b1, 1'b0);
    step("hold1",    8'hAA, 8'hBB, 8'hCC, 8'hDD, 2'd0, 1'b0, 1'b0);
    step("hold2",    8'h01, 8'h02, 8'h03, 8'h04, 2'd3, 1'b0, 1'b0);

    // full-width bit-exact copies
    step("ones",  8'hFF, 8'h00, 8'h80, 8'h01, 2'd0, 1'b1, 1'b0);
    step("msb",   8'hFF, 8'h00, 8'h80, 8'h01, 2'd2, 1'b1, 1'b0);
    step("zero",  8'hFF, 8'h00, 8'h80, 8'h01, 2'd1, 1'b1, 1'b0);

    // mid-cycle select glitch
    step("glitch0", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 2'd0, 1'b1, 1'b1);
    step("glitch2", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 2'd2, 1'b1, 1'b1);

    // async reset between edges, with dout=0x78
    step("pre_rst", 8'h12, 8'h34, 8'h56, 8'h78, 2'd3, 1'b1, 1'b0);
    #2; rst = 1'b1; #1;
    check_reset_vals("async_rst");
    m_dout = '0; m_sel = 2'd0;
    @(negedge clk);
    bus.en = 1'b1; bus.select = 2'd3; bus.din4 = 8'h9C;
    @(posedge clk); #1;
    check_reset_vals("rst_held");
    @(negedge clk); rst = 1'b0; bus.en = 1'b0;
    step("rst_idle",  8'h12, 8'h34, 8'h56, 8'h78, 2'd1, 1'b0, 1'b0);
    step("first_cap", 8'h5A, 8'h34, 8'h56, 8'h78, 2'd0, 1'b1, 1'b0);

`ifdef MUX4_PARITY_EN
    step("par_34", 8'h00, 8'h34, 8'h00, 8'h77, 2'd1, 1'b1, 1'b0);
    check("par_34.const", 64'(bus.dout_par), 64'd1);
    step("par_77", 8'h00, 8'h34, 8'h00, 8'h77, 2'd3, 1'b1, 1'b0);
    check("par_77.const", 64'(bus.dout_par), 64'd0);
    step("par_hold", 8'h01, 8'h01, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0);
`endif

    // random stress
    for (int i = 0; i < 1000; i++) begin
      step("rand",
           W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
